// File: rtl/videoram_scanout_reader_if.sv
// Videoram read port and pixel stream bundle for videoram_scanout_reader.
// master = the reader itself; slave = the videoram and pixel consumer side.
interface videoram_scanout_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8
) ();
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_rdata;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        output ram_addr, ram_rd, pix_data, pix_valid, pix_last,
        input  ram_rdata, pix_ready
    );
    modport slave (
        input  ram_addr, ram_rd, pix_data, pix_valid, pix_last,
        output ram_rdata, pix_ready
    );
endinterface

// File: rtl/videoram_scanout_reader.sv
// Streams one frame from a fixed-latency videoram port to a valid/ready pixel consumer.
// Optional stall statistics output enabled by defining VIDEORAM_SCANOUT_STATS_EN.
module videoram_scanout_reader #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int PIX_W       = 8,
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_WORDS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    videoram_scanout_reader_if.master bus,
    output logic              busy,
    output logic              frame_done
`ifdef VIDEORAM_SCANOUT_STATS_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);
    localparam int PPW       = DATA_W / PIX_W;
    localparam int TOTAL_PIX = FRAME_WORDS * PPW;
    localparam int CNT_W     = $clog2(FRAME_WORDS + 1);
    localparam int PIX_CNT_W = $clog2(TOTAL_PIX + 1);
    localparam int SUB_W     = $clog2(PPW + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int OCC_W     = $clog2(FIFO_DEPTH + RD_LAT + 3) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     base_r;
    logic [CNT_W-1:0]      issue_idx_r;
    logic [ADDR_W-1:0]     ram_addr_r;
    logic                  ram_rd_r;
    logic                  busy_r;
    logic                  frame_done_r;
    logic [RD_LAT-1:0]     lat_r;
    logic [DATA_W-1:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        fifo_cnt_r;
    logic [DATA_W-1:0]     hold_r;
    logic [SUB_W-1:0]      sub_r;
    logic                  hold_valid_r;
    logic                  last_r;
    logic [PIX_CNT_W-1:0]  pix_cnt_r;

    logic [OCC_W-1:0]      in_flight_s;
    logic [OCC_W-1:0]      occupancy_s;
    logic                  credit_s, emerge_s, fire_s, need_word_s, fifo_empty_s;
    logic                  pop_s, bypass_s, push_s, load_s, last_fire_s, accept_s;
    logic                  next_is_last_s;
    logic [DATA_W-1:0]     word_s;
    logic [PIX_CNT_W-1:0]  pix_cnt_nxt_s;

    // Count read tags still travelling through the latency delay line.
    always_comb begin
        in_flight_s = {OCC_W{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight_s = in_flight_s + OCC_W'(lat_r[i]);
        end
    end

    // Handshake, FIFO steering and fetch credit decode.
    always_comb begin
        emerge_s     = lat_r[RD_LAT-1];
        fire_s       = hold_valid_r & bus.pix_ready;
        need_word_s  = ~hold_valid_r | (fire_s & (sub_r == SUB_W'(1)));
        fifo_empty_s = (fifo_cnt_r == {(PTR_W+1){1'b0}});
        pop_s        = need_word_s & ~fifo_empty_s;
        // An empty FIFO lets returning data go straight into the holding register.
        bypass_s     = need_word_s & fifo_empty_s & emerge_s;
        push_s       = emerge_s & ~bypass_s;
        load_s       = pop_s | bypass_s;
        if (pop_s) begin
            word_s = fifo_mem_r[rd_ptr_r];
        end else begin
            word_s = bus.ram_rdata;
        end
        // The holding register and the read being issued now both consume credit.
        occupancy_s    = in_flight_s + OCC_W'(fifo_cnt_r) + OCC_W'(hold_valid_r) + OCC_W'(ram_rd_r);
        credit_s       = (occupancy_s < OCC_W'(FIFO_DEPTH));
        last_fire_s    = fire_s & last_r;
        accept_s       = (state_r == IDLE) & start & ~frame_done_r;
        pix_cnt_nxt_s  = pix_cnt_r + PIX_CNT_W'(fire_s);
        next_is_last_s = (pix_cnt_nxt_s == PIX_CNT_W'(TOTAL_PIX - 1));
    end

    // Frame sequencing and read address generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            base_r       <= {ADDR_W{1'b0}};
            issue_idx_r  <= {CNT_W{1'b0}};
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_rd_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_done_r <= 1'b0;
                    if (accept_s) begin
                        base_r      <= base_addr;
                        ram_addr_r  <= base_addr;
                        ram_rd_r    <= 1'b1;
                        issue_idx_r <= CNT_W'(1);
                        busy_r      <= 1'b1;
                        state_r     <= FETCH;
                    end else begin
                        ram_rd_r <= 1'b0;
                    end
                end
                FETCH: begin
                    frame_done_r <= 1'b0;
                    if (issue_idx_r == CNT_W'(FRAME_WORDS)) begin
                        ram_rd_r <= 1'b0;
                        state_r  <= DRAIN;
                    end else if (credit_s) begin
                        ram_rd_r    <= 1'b1;
                        ram_addr_r  <= base_r + ADDR_W'(issue_idx_r);
                        issue_idx_r <= issue_idx_r + CNT_W'(1);
                    end else begin
                        ram_rd_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    ram_rd_r <= 1'b0;
                    if (last_fire_s) begin
                        frame_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        frame_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    ram_rd_r     <= 1'b0;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency tag line and prefetch FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_r      <= {RD_LAT{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {(PTR_W+1){1'b0}};
        end else begin
            lat_r <= RD_LAT'({lat_r, ram_rd_r});
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W+1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W+1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Prefetch storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.ram_rdata;
        end
    end

    // Word-to-pixel unpacker, least-significant pixel first.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r       <= {DATA_W{1'b0}};
            sub_r        <= {SUB_W{1'b0}};
            hold_valid_r <= 1'b0;
            last_r       <= 1'b0;
            pix_cnt_r    <= {PIX_CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                pix_cnt_r <= {PIX_CNT_W{1'b0}};
            end else begin
                pix_cnt_r <= pix_cnt_nxt_s;
            end
            if (load_s) begin
                hold_r       <= word_s;
                sub_r        <= SUB_W'(PPW);
                hold_valid_r <= 1'b1;
                last_r       <= next_is_last_s;
            end else if (fire_s) begin
                hold_r       <= hold_r >> PIX_W;
                sub_r        <= sub_r - SUB_W'(1);
                hold_valid_r <= (sub_r != SUB_W'(1));
                last_r       <= next_is_last_s;
            end
        end
    end

`ifdef VIDEORAM_SCANOUT_STATS_EN
    logic [15:0] stall_r;

    // Saturating count of consumer back-pressure cycles within the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= 16'h0000;
        end else if (accept_s) begin
            stall_r <= 16'h0000;
        end else if (hold_valid_r && !bus.pix_ready && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end
    end

    assign stall_cycles = stall_r;
`endif

    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_rd    = ram_rd_r;
    assign bus.pix_data  = hold_r[PIX_W-1:0];
    assign bus.pix_valid = hold_valid_r;
    assign bus.pix_last  = last_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
endmodule
